// File: rtl/pe_pkg.sv
// Shared types and helpers for the streaming multiply-accumulate processing element.
// Bound helpers return a wide vector; callers slice off the low ACC_W bits.
package pe_pkg;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    ACCUM = 1'b1
  } acc_state_t;

  localparam int PE_MAX_W = 128;

  function automatic logic [PE_MAX_W-1:0] max_signed(input int w);
    return (PE_MAX_W'(1) << (w - 1)) - PE_MAX_W'(1);
  endfunction

  function automatic logic [PE_MAX_W-1:0] min_signed(input int w);
    return PE_MAX_W'(1) << (w - 1);
  endfunction

  function automatic logic [PE_MAX_W-1:0] max_unsigned(input int w);
    return (PE_MAX_W'(1) << w) - PE_MAX_W'(1);
  endfunction

  // The accumulator must hold at least one full-width product.
  function automatic bit widths_ok(input int acc_w, input int data_w);
    return acc_w >= 2 * data_w;
  endfunction

endpackage

// File: rtl/pe_sat_add.sv
// Combinational accumulate step: extend the product, add at ACC_W+1 bits,
// detect overflow and either clamp to the nearest bound or wrap.
module pe_sat_add
  import pe_pkg::*;
#(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 32,
  parameter bit SAT_EN = 1'b1
) (
  input  logic              i_signed,
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [PROD_W-1:0] i_prod,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_ovf
);

  localparam logic [PE_MAX_W-1:0] L_SMAX_WIDE = max_signed(ACC_W);
  localparam logic [PE_MAX_W-1:0] L_SMIN_WIDE = min_signed(ACC_W);
  localparam logic [PE_MAX_W-1:0] L_UMAX_WIDE = max_unsigned(ACC_W);
  localparam logic [ACC_W-1:0]    L_SMAX      = L_SMAX_WIDE[ACC_W-1:0];
  localparam logic [ACC_W-1:0]    L_SMIN      = L_SMIN_WIDE[ACC_W-1:0];
  localparam logic [ACC_W-1:0]    L_UMAX      = L_UMAX_WIDE[ACC_W-1:0];

  logic [ACC_W-1:0] w_prod_ext;
  logic [ACC_W:0]   w_sum_wide;
  logic [ACC_W-1:0] w_clamp;
  logic             w_ovf;

  if (ACC_W > PROD_W) begin : g_ext
    assign w_prod_ext = {{(ACC_W-PROD_W){i_signed & i_prod[PROD_W-1]}}, i_prod};
  end else begin : g_noext
    assign w_prod_ext = i_prod[ACC_W-1:0];
  end

  assign w_sum_wide = {i_signed & i_acc[ACC_W-1], i_acc}
                    + {i_signed & w_prod_ext[ACC_W-1], w_prod_ext};

  // Signed: the two top bits disagree when the sum leaves the ACC_W range.
  assign w_ovf   = i_signed ? (w_sum_wide[ACC_W] ^ w_sum_wide[ACC_W-1]) : w_sum_wide[ACC_W];
  assign w_clamp = !i_signed ? L_UMAX : (w_sum_wide[ACC_W] ? L_SMIN : L_SMAX);

  assign o_sum = (SAT_EN && w_ovf) ? w_clamp : w_sum_wide[ACC_W-1:0];
  assign o_ovf = w_ovf;

endmodule

// File: rtl/pe_mac_stream.sv
// Systolic MAC processing element with configurable widths, signed/unsigned mode,
// optional saturation, stream framing and a ready/valid result register.
module pe_mac_stream
  import pe_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 16,
  parameter bit SAT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode_signed,
  input  logic              fire,
  input  logic              in_last,
  input  logic [DATA_W-1:0] in_w,
  input  logic [DATA_W-1:0] in_a,
  output logic              out_f,
  output logic              out_last,
  output logic [DATA_W-1:0] out_w,
  output logic [DATA_W-1:0] out_a,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_ovf,
  output logic              err_overrun
);

  localparam int PROD_W = 2 * DATA_W;

  if (!widths_ok(ACC_W, DATA_W)) begin : g_width_check
    $error("pe_mac_stream: ACC_W must be at least 2*DATA_W");
  end

  acc_state_t        r_state;
  acc_state_t        w_state_next;
  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  w_acc_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              r_ovf;
  logic              w_ovf_next;

  logic              r_f;
  logic              r_last;
  logic [DATA_W-1:0] r_w;
  logic [DATA_W-1:0] r_a;

  logic              r_res_valid;
  logic [ACC_W-1:0]  r_res_data;
  logic [CNT_W-1:0]  r_res_count;
  logic              r_res_ovf;
  logic              r_err;

  logic [PROD_W-1:0] w_w_ext;
  logic [PROD_W-1:0] w_a_ext;
  logic [PROD_W-1:0] w_prod;
  logic [ACC_W-1:0]  w_sum;
  logic              w_add_ovf;
  logic              w_publish;
  logic [ACC_W-1:0]  w_pub_data;
  logic [CNT_W-1:0]  w_pub_count;
  logic              w_pub_ovf;

  // The low 2*DATA_W bits of the extended product are correct for both modes.
  assign w_w_ext = {{DATA_W{mode_signed & in_w[DATA_W-1]}}, in_w};
  assign w_a_ext = {{DATA_W{mode_signed & in_a[DATA_W-1]}}, in_a};
  assign w_prod  = w_w_ext * w_a_ext;

  pe_sat_add #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W),
    .SAT_EN (SAT_EN)
  ) u_sat_add (
    .i_signed (mode_signed),
    .i_acc    (r_acc),
    .i_prod   (w_prod),
    .o_sum    (w_sum),
    .o_ovf    (w_add_ovf)
  );

  assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      r_cnt   <= w_cnt_next;
      r_ovf   <= w_ovf_next;
    end
  end

  // In EMPTY the accumulator is zero, so the shared adder simply passes the product.
  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_cnt_next   = r_cnt;
    w_ovf_next   = r_ovf;
    w_publish    = 1'b0;
    w_pub_data   = w_sum;
    w_pub_count  = w_cnt_inc;
    w_pub_ovf    = r_ovf | w_add_ovf;
    case (r_state)
      EMPTY: begin
        if (fire) begin
          if (in_last) begin
            w_publish = 1'b1;
          end else begin
            w_state_next = ACCUM;
            w_acc_next   = w_sum;
            w_cnt_next   = w_cnt_inc;
            w_ovf_next   = r_ovf | w_add_ovf;
          end
        end
      end
      ACCUM: begin
        if (fire) begin
          if (in_last) begin
            w_publish    = 1'b1;
            w_state_next = EMPTY;
            w_acc_next   = '0;
            w_cnt_next   = '0;
            w_ovf_next   = 1'b0;
          end else begin
            w_acc_next = w_sum;
            w_cnt_next = w_cnt_inc;
            w_ovf_next = r_ovf | w_add_ovf;
          end
        end
      end
      default: w_state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_f    <= 1'b0;
      r_last <= 1'b0;
      r_w    <= '0;
      r_a    <= '0;
    end else begin
      r_f    <= fire;
      r_last <= fire & in_last;
      r_w    <= in_w;
      r_a    <= in_a;
    end
  end

  // Result slot: a publish always wins; overrun only when the old result was unclaimed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_count <= '0;
      r_res_ovf   <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_publish) begin
      r_res_valid <= 1'b1;
      r_res_data  <= w_pub_data;
      r_res_count <= w_pub_count;
      r_res_ovf   <= w_pub_ovf;
      if (r_res_valid && !res_ready) begin
        r_err <= 1'b1;
      end
    end else if (res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign out_f       = r_f;
  assign out_last    = r_last;
  assign out_w       = r_w;
  assign out_a       = r_a;
  assign res_valid   = r_res_valid;
  assign res_data    = r_res_data;
  assign res_count   = r_res_count;
  assign res_ovf     = r_res_ovf;
  assign err_overrun = r_err;

endmodule

// File: tb/tb_pe_mac_stream.sv
// Directed bench for pe_mac_stream: default 8/32 instance plus 8/16 saturating and wrapping instances.
module tb_pe_mac_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       mode_signed;
  logic       fire;
  logic       in_last;
  logic [7:0] in_w;
  logic [7:0] in_a;
  logic       res_ready;

  logic        d_out_f, d_out_last, d_res_valid, d_res_ovf, d_err;
  logic [7:0]  d_out_w, d_out_a;
  logic [31:0] d_res_data;
  logic [15:0] d_res_count;

  logic        s_out_f, s_out_last, s_res_valid, s_res_ovf, s_err;
  logic [7:0]  s_out_w, s_out_a;
  logic [15:0] s_res_data;
  logic [15:0] s_res_count;

  logic        w_out_f, w_out_last, w_res_valid, w_res_ovf, w_err;
  logic [7:0]  w_out_w, w_out_a;
  logic [15:0] w_res_data;
  logic [15:0] w_res_count;

  int n_checks = 0;
  int n_fail   = 0;

  pe_mac_stream u_dut (
    .clk(clk), .rst(rst), .mode_signed(mode_signed), .fire(fire), .in_last(in_last),
    .in_w(in_w), .in_a(in_a), .out_f(d_out_f), .out_last(d_out_last), .out_w(d_out_w),
    .out_a(d_out_a), .res_valid(d_res_valid), .res_ready(res_ready), .res_data(d_res_data),
    .res_count(d_res_count), .res_ovf(d_res_ovf), .err_overrun(d_err)
  );

  pe_mac_stream #(.DATA_W(8), .ACC_W(16), .CNT_W(16), .SAT_EN(1'b1)) u_sat16 (
    .clk(clk), .rst(rst), .mode_signed(mode_signed), .fire(fire), .in_last(in_last),
    .in_w(in_w), .in_a(in_a), .out_f(s_out_f), .out_last(s_out_last), .out_w(s_out_w),
    .out_a(s_out_a), .res_valid(s_res_valid), .res_ready(res_ready), .res_data(s_res_data),
    .res_count(s_res_count), .res_ovf(s_res_ovf), .err_overrun(s_err)
  );

  pe_mac_stream #(.DATA_W(8), .ACC_W(16), .CNT_W(16), .SAT_EN(1'b0)) u_wrap16 (
    .clk(clk), .rst(rst), .mode_signed(mode_signed), .fire(fire), .in_last(in_last),
    .in_w(in_w), .in_a(in_a), .out_f(w_out_f), .out_last(w_out_last), .out_w(w_out_w),
    .out_a(w_out_a), .res_valid(w_res_valid), .res_ready(res_ready), .res_data(w_res_data),
    .res_count(w_res_count), .res_ovf(w_res_ovf), .err_overrun(w_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // Drive one beat after a falling edge; the outputs it causes are checked at the next falling edge.
  task automatic beat(input logic [7:0] w, input logic [7:0] a, input logic last);
    fire    = 1'b1;
    in_w    = w;
    in_a    = a;
    in_last = last;
    @(negedge clk);
  endtask

  task automatic idle();
    fire    = 1'b0;
    in_last = 1'b0;
    in_w    = 8'h00;
    in_a    = 8'h00;
    @(negedge clk);
  endtask

  initial begin
    rst         = 1'b1;
    mode_signed = 1'b0;
    res_ready   = 1'b1;
    fire        = 1'b1;
    in_last     = 1'b1;
    in_w        = 8'h55;
    in_a        = 8'hAA;
    @(negedge clk);
    @(negedge clk);
    check("rst_out_f", 64'(d_out_f), 64'(0));
    check("rst_out_w", 64'(d_out_w), 64'(0));
    check("rst_res_valid", 64'(d_res_valid), 64'(0));
    check("rst_res_data", 64'(d_res_data), 64'(0));
    check("rst_err", 64'(d_err), 64'(0));
    rst = 1'b0;
    idle();

    // Unsigned 16-beat dot product: sum i*(i+1), i=0..15 = 1360
    for (int i = 0; i < 16; i++) begin
      beat(8'(i), 8'(i + 1), (i == 15));
      check("t1_out_w", 64'(d_out_w), 64'(i));
      check("t1_out_a", 64'(d_out_a), 64'(i + 1));
    end
    check("t1_out_last", 64'(d_out_last), 64'(1));
    check("t1_valid", 64'(d_res_valid), 64'(1));
    check("t1_data", 64'(d_res_data), 64'(1360));
    check("t1_count", 64'(d_res_count), 64'(16));
    check("t1_ovf", 64'(d_res_ovf), 64'(0));
    idle();
    check("t1_valid_clr", 64'(d_res_valid), 64'(0));
    check("t1_data_hold", 64'(d_res_data), 64'(1360));
    check("t1_out_f_idle", 64'(d_out_f), 64'(0));

    // Signed: -15 - 14 + 16384 = 16355
    mode_signed = 1'b1;
    beat(8'hFD, 8'h05, 1'b0);
    beat(8'h07, 8'hFE, 1'b0);
    beat(8'h80, 8'h80, 1'b1);
    check("t2_data", 64'(d_res_data), 64'(16355));
    check("t2_count", 64'(d_res_count), 64'(3));
    check("t2_ovf", 64'(d_res_ovf), 64'(0));
    check("t2_data16", 64'(s_res_data), 64'(16355));
    idle();

    // Four beats of 127*127 = 16129 in a 16-bit signed accumulator
    for (int i = 0; i < 4; i++) begin
      beat(8'd127, 8'd127, (i == 3));
    end
    check("t3_sat_data", 64'(s_res_data), 64'(16'h7FFF));
    check("t3_sat_ovf", 64'(s_res_ovf), 64'(1));
    check("t3_sat_count", 64'(s_res_count), 64'(4));
    check("t3_wrap_data", 64'(w_res_data), 64'(16'hFC04));
    check("t3_wrap_ovf", 64'(w_res_ovf), 64'(1));
    check("t3_wide_data", 64'(d_res_data), 64'(64516));
    check("t3_wide_ovf", 64'(d_res_ovf), 64'(0));
    idle();

    // Back-to-back single-beat results
    mode_signed = 1'b0;
    beat(8'd2, 8'd3, 1'b1);
    check("t4_valid0", 64'(d_res_valid), 64'(1));
    check("t4_data0", 64'(d_res_data), 64'(6));
    beat(8'd4, 8'd5, 1'b1);
    check("t4_valid1", 64'(d_res_valid), 64'(1));
    check("t4_data1", 64'(d_res_data), 64'(20));
    beat(8'd6, 8'd7, 1'b1);
    check("t4_data2", 64'(d_res_data), 64'(42));
    check("t4_count2", 64'(d_res_count), 64'(1));
    check("t4_err", 64'(d_err), 64'(0));
    idle();

    // Overrun with the consumer stalled
    res_ready = 1'b0;
    beat(8'd1, 8'd2, 1'b1);
    check("t5_data0", 64'(d_res_data), 64'(2));
    check("t5_err0", 64'(d_err), 64'(0));
    beat(8'd3, 8'd4, 1'b1);
    check("t5_data1", 64'(d_res_data), 64'(12));
    check("t5_err1", 64'(d_err), 64'(1));
    idle();
    check("t5_valid_held", 64'(d_res_valid), 64'(1));
    check("t5_err_sticky", 64'(d_err), 64'(1));
    res_ready = 1'b1;
    idle();
    check("t5_valid_clr", 64'(d_res_valid), 64'(0));
    check("t5_err_still", 64'(d_err), 64'(1));

    // Reset in the middle of an accumulation, overriding a fired last beat
    for (int i = 0; i < 5; i++) begin
      beat(8'd1, 8'd1, 1'b0);
    end
    rst = 1'b1;
    beat(8'h33, 8'h44, 1'b1);
    check("t6_out_f", 64'(d_out_f), 64'(0));
    check("t6_out_last", 64'(d_out_last), 64'(0));
    check("t6_out_w", 64'(d_out_w), 64'(0));
    check("t6_out_a", 64'(d_out_a), 64'(0));
    check("t6_valid", 64'(d_res_valid), 64'(0));
    check("t6_data", 64'(d_res_data), 64'(0));
    check("t6_count", 64'(d_res_count), 64'(0));
    check("t6_err", 64'(d_err), 64'(0));
    rst = 1'b0;
    beat(8'd1, 8'd1, 1'b0);
    beat(8'd1, 8'd1, 1'b1);
    check("t6_post_data", 64'(d_res_data), 64'(2));
    check("t6_post_count", 64'(d_res_count), 64'(2));
    check("t6_post_valid", 64'(d_res_valid), 64'(1));
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
